// File: rtl/can_frame_tx.sv
// CAN 2.0A classic-frame transmitter: latches one message, appends CRC-15,
// bit-stuffs SOF..CRC and serialises at CLKS_PER_BIT clocks per bit.
module can_frame_tx #(
  parameter int MAX_BYTES    = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic [10:0]            msg_id_i,
  input  logic                   rtr_i,
  input  logic [3:0]             dlc_i,
  input  logic [8*MAX_BYTES-1:0] data_i,
  input  logic                   start_i,
  output logic                   ready_o,
  output logic                   serial_o,
  output logic                   bit_strobe_o,
  output logic                   stuff_o,
  output logic                   done_o
);

  localparam int DW = 8 * MAX_BYTES;
  localparam int IW = $clog2(DW);
  localparam int PW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [PW-1:0] PRELOAD = PW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    MAXB    = 4'(MAX_BYTES);
  localparam logic [14:0]   POLY    = 15'h4599;

  typedef enum logic [3:0] {
    S_IDLE, S_SOF, S_ID, S_RTR, S_CTRL, S_DATA,
    S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_IFS
  } state_t;

  state_t        st;
  state_t        nst;
  logic [6:0]    idx;
  logic [6:0]    nidx;
  logic [6:0]    nbits;
  logic [PW-1:0] presc;
  logic [14:0]   crc_q;
  logic [14:0]   crc_upd;
  logic [2:0]    run;
  logic          last_q;
  logic          in_stuff;
  logic          nbit;
  logic          fb;
  logic          last_ifs;
  logic          crc_zone;
  logic          stuff_zone;
  logic [10:0]   id_q;
  logic          rtr_q;
  logic [3:0]    dlc_q;
  logic [3:0]    nbytes_q;
  logic [DW-1:0] data_q;

  assign nbits = {nbytes_q, 3'b000};

  // (st, idx) names the field bit last put on the wire; stuff bits do not move it
  always_comb begin
    nst      = st;
    nidx     = idx + 7'd1;
    last_ifs = 1'b0;
    unique case (st)
      S_SOF: begin
        nst  = S_ID;
        nidx = '0;
      end
      S_ID:
        if (idx == 7'd10) begin
          nst  = S_RTR;
          nidx = '0;
        end
      S_RTR: begin
        nst  = S_CTRL;
        nidx = '0;
      end
      S_CTRL:
        if (idx == 7'd5) begin
          nst  = (nbytes_q != 4'd0) ? S_DATA : S_CRC;
          nidx = '0;
        end
      S_DATA:
        if (idx == nbits - 7'd1) begin
          nst  = S_CRC;
          nidx = '0;
        end
      S_CRC:
        if (idx == 7'd14) begin
          nst  = S_CRC_DEL;
          nidx = '0;
        end
      S_CRC_DEL: begin
        nst  = S_ACK;
        nidx = '0;
      end
      S_ACK: begin
        nst  = S_ACK_DEL;
        nidx = '0;
      end
      S_ACK_DEL: begin
        nst  = S_EOF;
        nidx = '0;
      end
      S_EOF:
        if (idx == 7'd6) begin
          nst  = S_IFS;
          nidx = '0;
        end
      S_IFS:
        if (idx == 7'd2) begin
          nst      = S_IDLE;
          last_ifs = 1'b1;
        end
      default: nst = S_IDLE;
    endcase
  end

  always_comb begin
    nbit = 1'b1;
    unique case (nst)
      S_ID:    nbit = id_q[4'd10 - nidx[3:0]];
      S_RTR:   nbit = rtr_q;
      S_CTRL:  nbit = (nidx < 7'd2) ? 1'b0
                    : dlc_q[2'(3'd5 - nidx[2:0])];
      S_DATA:  nbit = data_q[IW'(DW - 1) - nidx[IW-1:0]];
      S_CRC:   nbit = crc_q[4'd14 - nidx[3:0]];
      default: nbit = 1'b1;
    endcase
  end

  assign fb         = nbit ^ crc_q[14];
  assign crc_upd    = {crc_q[13:0], 1'b0} ^ (fb ? POLY : 15'd0);
  assign crc_zone   = nst inside {S_ID, S_RTR, S_CTRL, S_DATA};
  assign stuff_zone = crc_zone || (nst == S_CRC);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      st           <= S_IDLE;
      idx          <= '0;
      presc        <= '0;
      crc_q        <= '0;
      run          <= '0;
      last_q       <= 1'b0;
      in_stuff     <= 1'b0;
      id_q         <= '0;
      rtr_q        <= 1'b0;
      dlc_q        <= '0;
      nbytes_q     <= '0;
      data_q       <= '0;
      ready_o      <= 1'b1;
      serial_o     <= 1'b1;
      bit_strobe_o <= 1'b0;
      stuff_o      <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      bit_strobe_o <= 1'b0;
      done_o       <= 1'b0;
      if (st == S_IDLE) begin
        if (start_i && ready_o) begin
          id_q         <= msg_id_i;
          rtr_q        <= rtr_i;
          dlc_q        <= dlc_i;
          data_q       <= data_i;
          nbytes_q     <= rtr_i ? 4'd0
                        : (dlc_i > MAXB) ? MAXB : dlc_i;
          st           <= S_SOF;
          idx          <= '0;
          presc        <= PRELOAD;
          crc_q        <= '0;
          run          <= 3'd1;
          last_q       <= 1'b0;
          in_stuff     <= 1'b1;
          ready_o      <= 1'b0;
          serial_o     <= 1'b0;
          bit_strobe_o <= 1'b1;
          stuff_o      <= 1'b0;
        end
      end else if (presc != '0) begin
        presc <= presc - PW'(1);
      end else begin
        presc <= PRELOAD;
        if (in_stuff && run == 3'd5) begin
          serial_o     <= ~last_q;
          last_q       <= ~last_q;
          run          <= 3'd1;
          stuff_o      <= 1'b1;
          bit_strobe_o <= 1'b1;
        end else if (last_ifs) begin
          st       <= S_IDLE;
          ready_o  <= 1'b1;
          done_o   <= 1'b1;
          serial_o <= 1'b1;
          stuff_o  <= 1'b0;
        end else begin
          st           <= nst;
          idx          <= nidx;
          serial_o     <= nbit;
          bit_strobe_o <= 1'b1;
          stuff_o      <= 1'b0;
          if (crc_zone)
            crc_q <= crc_upd;
          if (stuff_zone) begin
            in_stuff <= 1'b1;
            last_q   <= nbit;
            run      <= (nbit == last_q) ? run + 3'd1 : 3'd1;
          end else begin
            in_stuff <= 1'b0;
            run      <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_can_frame_tx.sv
// Directed bench for can_frame_tx: two instances (8 bytes / 1 clk per bit,
// 4 bytes / 4 clks per bit) driven with hand-checked frames.
module tb_can_frame_tx;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [10:0] msg_id;
  logic        rtr;
  logic [3:0]  dlc;
  logic [63:0] data_a;
  logic [31:0] data_b;
  logic        start_a, start_b;
  logic        ready_a, serial_a, strobe_a, stuff_a, done_a;
  logic        ready_b, serial_b, strobe_b, stuff_b, done_b;
  bit          which;
  logic        o_ready, o_serial, o_strobe, o_stuff, o_done;

  int n_vec = 0;
  int n_bad = 0;
  int ncyc, nalign, nstfcyc, len2, nst;
  logic [127:0] v;
  bit cap_bit[$], cap_stf[$], exp_bit[$], exp_stf[$], ds[$];

  always #5 clock = ~clock;

  can_frame_tx #(.MAX_BYTES(8), .CLKS_PER_BIT(1)) u_a (
    .clock_i(clock), .reset_ni(reset_n), .msg_id_i(msg_id),
    .rtr_i(rtr), .dlc_i(dlc), .data_i(data_a), .start_i(start_a),
    .ready_o(ready_a), .serial_o(serial_a), .bit_strobe_o(strobe_a),
    .stuff_o(stuff_a), .done_o(done_a)
  );

  can_frame_tx #(.MAX_BYTES(4), .CLKS_PER_BIT(4)) u_b (
    .clock_i(clock), .reset_ni(reset_n), .msg_id_i(msg_id),
    .rtr_i(rtr), .dlc_i(dlc), .data_i(data_b), .start_i(start_b),
    .ready_o(ready_b), .serial_o(serial_b), .bit_strobe_o(strobe_b),
    .stuff_o(stuff_b), .done_o(done_b)
  );

  assign o_ready  = which ? ready_b  : ready_a;
  assign o_serial = which ? serial_b : serial_a;
  assign o_strobe = which ? strobe_b : strobe_a;
  assign o_stuff  = which ? stuff_b  : stuff_a;
  assign o_done   = which ? done_b   : done_a;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // reference frame: unstuffed fields, CRC-15, stuffing, then 13 trailing ones
  task automatic build(input logic [10:0] id, input logic r,
                       input logic [3:0] d, input logic [63:0] pay,
                       input int maxb);
    bit ub[$];
    logic [14:0] crc;
    int nb, run;
    bit last, fb;
    ub.push_back(1'b0);
    for (int i = 10; i >= 0; i--) ub.push_back(id[i]);
    ub.push_back(r);
    ub.push_back(1'b0);
    ub.push_back(1'b0);
    for (int i = 3; i >= 0; i--) ub.push_back(d[i]);
    nb = r ? 0 : ((int'(d) > maxb) ? maxb : int'(d));
    for (int i = 0; i < 8 * nb; i++) ub.push_back(pay[63-i]);
    crc = '0;
    foreach (ub[i]) begin
      fb  = ub[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (fb) crc ^= 15'h4599;
    end
    for (int i = 14; i >= 0; i--) ub.push_back(crc[i]);
    exp_bit.delete();
    exp_stf.delete();
    run  = 0;
    last = 1'b0;
    foreach (ub[i]) begin
      exp_bit.push_back(ub[i]);
      exp_stf.push_back(1'b0);
      run  = (run > 0 && ub[i] == last) ? run + 1 : 1;
      last = ub[i];
      if (run == 5) begin
        exp_bit.push_back(!last);
        exp_stf.push_back(1'b1);
        last = !last;
        run  = 1;
      end
    end
    repeat (13) begin
      exp_bit.push_back(1'b1);
      exp_stf.push_back(1'b0);
    end
  endtask

  function automatic int qdiff();
    int n, m;
    n = (cap_bit.size() > exp_bit.size()) ? cap_bit.size() - exp_bit.size()
                                          : exp_bit.size() - cap_bit.size();
    m = (cap_bit.size() < exp_bit.size()) ? cap_bit.size() : exp_bit.size();
    for (int i = 0; i < m; i++)
      if (cap_bit[i] != exp_bit[i] || cap_stf[i] != exp_stf[i]) n++;
    return n;
  endfunction

  task automatic destuff();
    ds.delete();
    foreach (cap_bit[i]) if (!cap_stf[i]) ds.push_back(cap_bit[i]);
  endtask

  function automatic logic [127:0] fld(input int from, input int len);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < len; i++)
      r = {r[126:0], (from + i < ds.size()) ? ds[from+i] : 1'b1};
    return r;
  endfunction

  task automatic kick(input bit s);
    which = s;
    @(negedge clock);
    if (s) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    check("sof hs", {o_ready, o_strobe, o_serial}, 3'b010);
  endtask

  // entered on the negedge of the SOF cycle; leaves on the done_o cycle
  task automatic grab(input int pulse_at);
    bit prev, fin;
    cap_bit.delete();
    cap_stf.delete();
    ncyc = 0; nalign = 0; nstfcyc = 0;
    prev = 1'b1; fin = 1'b0;
    while (!fin && ncyc < 4000) begin
      if (o_done) fin = 1'b1;
      else begin
        if (o_strobe) begin
          cap_bit.push_back(o_serial);
          cap_stf.push_back(o_stuff);
        end else if (o_serial != prev) nalign++;
        if (o_stuff) nstfcyc++;
        prev = o_serial;
        ncyc++;
        if (which) start_b = (ncyc == pulse_at);
        else       start_a = (ncyc == pulse_at);
        @(negedge clock);
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check("done seen", fin, 1'b1);
    check("done idle", {o_ready, o_serial}, 2'b11);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0; which = 1'b0;
    msg_id = '0; rtr = 1'b0; dlc = '0; data_a = '0; data_b = '0;
    repeat (3) @(negedge clock);
    check("rst a", {serial_a, ready_a, done_a, strobe_a, stuff_a}, 5'b11000);
    check("rst b", {serial_b, ready_b, done_b, strobe_b, stuff_b}, 5'b11000);
    reset_n = 1'b1;

    // all-zero frame
    kick(0);
    grab(0);
    build(11'h000, 1'b0, 4'd0, 64'h0, 8);
    check("t1 nbits", cap_bit.size(), 53);
    check("t1 stuff", nstfcyc, 6);
    check("t1 cycles", ncyc, 53);
    v = '0;
    for (int i = 0; i < 53 && i < cap_bit.size(); i++) v = {v[126:0], cap_bit[i]};
    check("t1 stream", v, {{6{6'b000001}}, 4'b0000, 13'h1FFF});
    check("t1 model", qdiff(), 0);
    destuff();
    check("t1 crc", fld(19, 15), 15'h0000);

    // 0x123 / DEADBEEF
    msg_id = 11'h123; dlc = 4'd4; data_a = 64'hDEADBEEF_00000000;
    kick(0);
    grab(0);
    build(msg_id, 1'b0, dlc, data_a, 8);
    destuff();
    check("t2 fields", fld(0, 66),
          {1'b0, 11'h123, 1'b0, 2'b00, 4'b0100, 32'hDEADBEEF, 15'h4E6B});
    check("t2 model", qdiff(), 0);
    len2 = cap_bit.size();

    // start during done_o: back-to-back frame
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    check("b2b sof", {o_ready, o_strobe, o_serial}, 3'b010);
    grab(0);
    check("b2b model", qdiff(), 0);

    // same frame, 4 clocks per bit
    data_b = 32'hDEADBEEF;
    kick(1);
    grab(0);
    build(msg_id, 1'b0, dlc, {data_b, 32'h0}, 4);
    check("t3 model", qdiff(), 0);
    check("t3 cycles", ncyc, 4 * len2);
    check("t3 align", nalign, 0);
    nst = 0;
    foreach (cap_stf[i]) if (cap_stf[i]) nst++;
    check("t3 stuff len", nstfcyc, 4 * nst);

    // remote frame, all-ones ID
    msg_id = 11'h7FF; rtr = 1'b1; dlc = 4'd8;
    kick(0);
    grab(0);
    build(msg_id, rtr, dlc, data_a, 8);
    destuff();
    check("t4 dlc", fld(15, 4), 4'b1000);
    check("t4 nbits", ds.size(), 47);
    check("t4 stuff0", {cap_bit[6], cap_stf[6]}, 2'b01);
    check("t4 model", qdiff(), 0);

    // DLC 15 clamps to 8 bytes; mid-frame start ignored
    msg_id = 11'h2A5; rtr = 1'b0; dlc = 4'd15; data_a = 64'h0123456789ABCDEF;
    kick(0);
    grab(40);
    build(msg_id, rtr, dlc, data_a, 8);
    destuff();
    check("t5 dlc", fld(15, 4), 4'b1111);
    check("t5 nbits", ds.size(), 111);
    check("t5 model", qdiff(), 0);
    repeat (3) @(negedge clock);
    check("t5 no restart", {o_ready, o_strobe}, 2'b10);

    // reset during DATA, then a clean frame
    msg_id = 11'h155; dlc = 4'd8; data_a = 64'hFFFF0000A5A5C3C3;
    kick(0);
    repeat (30) @(negedge clock);
    #1 reset_n = 1'b0;
    #1 check("t6 abort", {serial_a, ready_a, strobe_a, stuff_a}, 4'b1100);
    @(negedge clock);
    reset_n = 1'b1;
    kick(0);
    grab(0);
    build(msg_id, rtr, dlc, data_a, 8);
    check("t6 model", qdiff(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
